// File: rtl/adc_cycle_reader.sv
// Conversion sequencer and synchronous-demodulation accumulator for an SPI-read ADC.
// Runs one measurement cycle per start command and returns two half-period sums or one raw sample.
module adc_cycle_reader #(
   parameter int unsigned OUTPUT_DATA_WIDTH = 24,
   parameter int unsigned ADC_BITS          = 18,
   parameter int unsigned SAMPLES_PER_CYCLE = 64,
   parameter int unsigned SCK_HALF          = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sample_adc,
   input  logic                         start_cycle_conv,
   input  logic                         halfcycle,
   input  logic                         read_diapason,
   output logic                         complete,
   output logic [OUTPUT_DATA_WIDTH-1:0] data_out_1,
   output logic [OUTPUT_DATA_WIDTH-1:0] data_out_2,
   output logic                         cnv,
   input  logic                         adc_busy,
   input  logic                         miso,
   output logic                         sck
);

   localparam int unsigned CNT_W = $clog2(SAMPLES_PER_CYCLE + 1);
   localparam int unsigned BIT_W = $clog2(ADC_BITS + 1);
   localparam int unsigned PH_W  = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
   localparam int unsigned EXT_W = OUTPUT_DATA_WIDTH - ADC_BITS;

   typedef enum logic [2:0] {
      S_IDLE, S_ARMED, S_CNV, S_WAIT_BUSY, S_SHIFT, S_ACCUM, S_DONE
   } state_t;

   state_t                         state;
   logic                           busy_meta, busy_sync;
   logic                           probe, half_sel;
   logic [OUTPUT_DATA_WIDTH-1:0]   acc1, acc2;
   logic [CNT_W-1:0]               cnt;
   logic [1:0]                     timer;
   logic [PH_W-1:0]                ph;
   logic [BIT_W-1:0]               bit_cnt;
   logic [ADC_BITS-1:0]            shreg;
   logic [OUTPUT_DATA_WIDTH-1:0]   sample_ext, acc1_sum, acc2_sum;
   logic [CNT_W-1:0]               cnt_inc;

   // Sign-extended sample and the candidate sums for the ACCUM step
   always_comb begin
      sample_ext = {{EXT_W{shreg[ADC_BITS-1]}}, shreg};
      acc1_sum   = acc1 + sample_ext;
      acc2_sum   = acc2 + sample_ext;
      cnt_inc    = cnt + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_meta <= 1'b0;
         busy_sync <= 1'b0;
      end else begin
         busy_meta <= adc_busy;
         busy_sync <= busy_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         probe      <= 1'b0;
         half_sel   <= 1'b0;
         acc1       <= '0;
         acc2       <= '0;
         cnt        <= '0;
         timer      <= '0;
         ph         <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         complete   <= 1'b0;
         data_out_1 <= '0;
         data_out_2 <= '0;
         cnv        <= 1'b0;
         sck        <= 1'b0;
      end else begin
         complete <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_cycle_conv) begin
                  probe <= read_diapason;
                  acc1  <= '0;
                  acc2  <= '0;
                  cnt   <= '0;
                  state <= S_ARMED;
               end
            end
            S_ARMED: begin
               if (sample_adc) begin
                  half_sel <= halfcycle;
                  cnv      <= 1'b1;
                  timer    <= '0;
                  state    <= S_CNV;
               end
            end
            S_CNV: begin
               if (timer == 2'd1) begin
                  cnv   <= 1'b0;
                  timer <= '0;
                  state <= S_WAIT_BUSY;
               end else begin
                  timer <= timer + 2'd1;
               end
            end
            S_WAIT_BUSY: begin
               // Minimum dwell of three clocks before trusting the synchronized busy
               if (timer != 2'd2) begin
                  timer <= timer + 2'd1;
               end else if (!busy_sync) begin
                  sck     <= 1'b1;
                  ph      <= '0;
                  bit_cnt <= '0;
                  state   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (ph != PH_W'(SCK_HALF - 1)) begin
                  ph <= ph + PH_W'(1);
               end else begin
                  ph <= '0;
                  if (sck) begin
                     shreg   <= {shreg[ADC_BITS-2:0], miso};
                     bit_cnt <= bit_cnt + BIT_W'(1);
                     sck     <= 1'b0;
                  end else if (bit_cnt == BIT_W'(ADC_BITS)) begin
                     state <= S_ACCUM;
                  end else begin
                     sck <= 1'b1;
                  end
               end
            end
            S_ACCUM: begin
               cnt <= cnt_inc;
               if (!half_sel) acc1 <= acc1_sum;
               else           acc2 <= acc2_sum;
               // Outputs load here so they are valid alongside the complete pulse
               if (probe || cnt_inc == CNT_W'(SAMPLES_PER_CYCLE)) begin
                  complete   <= 1'b1;
                  data_out_1 <= probe ? sample_ext : (half_sel ? acc1 : acc1_sum);
                  data_out_2 <= probe ? '0 : (half_sel ? acc2_sum : acc2);
                  state      <= S_DONE;
               end else begin
                  state <= S_ARMED;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_cycle_reader.sv
// Directed/randomized bench for adc_cycle_reader with a behavioural ADC and an arithmetic sum model.
module tb_adc_cycle_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        sample_adc, start_cycle_conv, halfcycle, read_diapason;
   logic        complete, cnv, adc_busy, miso, sck;
   logic [23:0] data_out_1, data_out_2;

   int          checks = 0;
   int          passed = 0;
   int          fails  = 0;
   int          cmp_cnt = 0;
   int          sck_cnt = 0;
   int          cnv_cnt = 0;
   logic [23:0] cap1, cap2;
   logic [17:0] adc_word, cur_word;
   int          bit_idx;
   logic [17:0] words [64];
   bit          halves[64];

   adc_cycle_reader dut (
      .clk(clk), .rst(rst), .sample_adc(sample_adc), .start_cycle_conv(start_cycle_conv),
      .halfcycle(halfcycle), .read_diapason(read_diapason), .complete(complete),
      .data_out_1(data_out_1), .data_out_2(data_out_2), .cnv(cnv), .adc_busy(adc_busy),
      .miso(miso), .sck(sck)
   );

   always #5 clk = ~clk;

   // ADC data path: latch word on conversion start, present next bit on each SCK rise
   always @(posedge sck or posedge cnv) begin
      if (cnv) begin
         cur_word = adc_word;
         bit_idx  = 17;
      end else begin
         sck_cnt++;
         if (bit_idx >= 0) miso = cur_word[bit_idx];
         bit_idx--;
      end
   end

   // ADC busy lasts 10 clocks after each conversion start
   always @(posedge cnv) begin
      cnv_cnt++;
      adc_busy <= 1'b1;
      repeat (10) @(posedge clk);
      adc_busy <= 1'b0;
   end

   always @(negedge clk) begin
      if (complete === 1'b1) begin
         cmp_cnt++;
         cap1 = data_out_1;
         cap2 = data_out_2;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_strobe(input logic [17:0] w, input bit h, input bit inject);
      @(negedge clk);
      adc_word = w; halfcycle = h; sample_adc = 1'b1;
      @(negedge clk);
      sample_adc = 1'b0; halfcycle = ~h;
      if (inject) begin
         repeat (24) @(negedge clk);
         sample_adc = 1'b1; start_cycle_conv = 1'b1;
         @(negedge clk);
         sample_adc = 1'b0; start_cycle_conv = 1'b0;
         repeat (40) @(negedge clk);
      end else begin
         repeat (64) @(negedge clk);
      end
   endtask

   task automatic run_cycle(input bit probe, input int n, input bit inject, input bit same_clk,
                            input string tag);
      int          s1, s2, v, v0, c0, k0, n0;
      logic [23:0] e1, e2;
      s1 = 0; s2 = 0; v0 = 0;
      for (int i = 0; i < n; i++) begin
         v = words[i][17] ? int'(words[i]) - 262144 : int'(words[i]);
         if (i == 0) v0 = v;
         if (halves[i]) s2 += v; else s1 += v;
      end
      e1 = probe ? 24'(v0) : 24'(s1);
      e2 = probe ? 24'd0 : 24'(s2);
      c0 = cmp_cnt; k0 = sck_cnt;
      @(negedge clk);
      read_diapason = probe; start_cycle_conv = 1'b1; sample_adc = same_clk;
      @(negedge clk);
      start_cycle_conv = 1'b0; sample_adc = 1'b0; read_diapason = ~probe;
      if (same_clk) begin
         n0 = cnv_cnt;
         repeat (5) @(negedge clk);
         check({tag, " same_clk_drop"}, cnv_cnt - n0, 0);
      end
      for (int i = 0; i < n; i++) do_strobe(words[i], halves[i], inject && i == 3);
      check({tag, " complete_count"}, cmp_cnt - c0, 1);
      check({tag, " sck_pulses"}, sck_cnt - k0, n * 18);
      check({tag, " data_out_1"}, {8'h0, cap1}, {8'h0, e1});
      check({tag, " data_out_2"}, {8'h0, cap2}, {8'h0, e2});
      check({tag, " hold_1"}, {8'h0, data_out_1}, {8'h0, e1});
   endtask

   initial begin
      rst = 1'b1; sample_adc = 1'b0; start_cycle_conv = 1'b0; halfcycle = 1'b0;
      read_diapason = 1'b0; adc_busy = 1'b0; miso = 1'b0; adc_word = '0;
      repeat (2) @(negedge clk);
      check("reset complete", {31'h0, complete}, 0);
      check("reset cnv", {31'h0, cnv}, 0);
      check("reset sck", {31'h0, sck}, 0);
      check("reset data_out_1", {8'h0, data_out_1}, 0);
      check("reset data_out_2", {8'h0, data_out_2}, 0);
      rst = 1'b0;

      // Strobes without a start command must cause no activity
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); sample_adc = 1'b1;
         @(negedge clk); sample_adc = 1'b0;
      end
      repeat (10) @(negedge clk);
      check("idle cnv_count", cnv_cnt, 0);
      check("idle sck_count", sck_cnt, 0);
      check("idle complete_count", cmp_cnt, 0);

      words[0] = 18'h20001; halves[0] = 1'b1;
      run_cycle(1'b1, 1, 1'b0, 1'b0, "probe");

      for (int i = 0; i < 64; i++) begin words[i] = 18'd100; halves[i] = (i >= 32); end
      run_cycle(1'b0, 64, 1'b0, 1'b0, "normal");

      for (int i = 0; i < 64; i++) begin
         halves[i] = (i >= 32);
         words[i]  = halves[i] ? 18'h1FFFF : 18'h20000;
      end
      run_cycle(1'b0, 64, 1'b0, 1'b0, "sign");

      for (int i = 0; i < 64; i++) begin
         words[i] = 18'($urandom); halves[i] = bit'($urandom_range(0, 1));
      end
      run_cycle(1'b0, 64, 1'b1, 1'b0, "rand_inject");

      // Abort mid-SHIFT, then confirm a fresh cycle starts from zero
      begin
         int c0;
         c0 = cmp_cnt;
         @(negedge clk); start_cycle_conv = 1'b1;
         @(negedge clk); start_cycle_conv = 1'b0;
         adc_word = 18'h15555; sample_adc = 1'b1;
         @(negedge clk); sample_adc = 1'b0;
         repeat (25) @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         check("abort sck_low", {31'h0, sck}, 0);
         check("abort cnv_low", {31'h0, cnv}, 0);
         rst = 1'b0;
         repeat (70) @(negedge clk);
         check("abort no_complete", cmp_cnt - c0, 0);
      end

      for (int i = 0; i < 64; i++) begin
         words[i] = 18'($urandom); halves[i] = bit'($urandom_range(0, 1));
      end
      run_cycle(1'b0, 64, 1'b0, 1'b1, "after_abort");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
